// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier (8x8 / 16x16) that borrows the shared core ALU
// for one add per multiplier bit. The product is registered on entry to DONE.
module alu_mul_seq #(
  parameter logic CE_GATE = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ce,
  input  logic        i_start,
  input  logic        i_w16,
  input  logic [15:0] i_mcand,
  input  logic [15:0] i_mplier,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_prod,
  output logic        o_alu_own,
  output logic [15:0] o_alu_l,
  output logic [15:0] o_alu_r,
  output logic [2:0]  o_alu_fstop,
  output logic [2:0]  o_alu_secop,
  output logic        o_alu_fc,
  output logic        o_alu_w16,
  output logic        o_alu_bcd,
  output logic        o_alu_ci,
  input  logic [15:0] i_alu_res,
  input  logic        i_alu_co
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [15:0] r_acc;
  logic [15:0] r_q;
  logic [15:0] r_mc;
  logic [3:0]  r_cnt;
  logic        r_wr;
  logic [31:0] r_prod;

  logic        w_adv;
  logic        w_load;
  logic        w_step;
  logic        w_last;
  logic [15:0] w_acc_nx;
  logic [15:0] w_q_nx;

  assign w_adv  = CE_GATE ? i_ce : 1'b1;
  assign w_load = w_adv && (r_state == S_IDLE) && i_start;
  assign w_step = w_adv && (r_state == S_RUN);
  assign w_last = w_step && (r_cnt == 4'd0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_alu_l     = 16'h0000;
    o_alu_r     = 16'h0000;
    o_alu_fstop = 3'b000;
    o_alu_secop = 3'b000;
    o_alu_fc    = 1'b0;
    o_alu_w16   = 1'b0;
    o_alu_bcd   = 1'b0;
    o_alu_ci    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_load) w_state_nx = S_RUN;
      end
      S_RUN: begin
        o_busy      = 1'b1;
        o_alu_l     = r_acc;
        o_alu_r     = r_q[0] ? r_mc : 16'h0000;
        o_alu_fstop = 3'b100;
        o_alu_secop = 3'b011;
        o_alu_w16   = r_wr;
        if (w_last) w_state_nx = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        if (w_adv) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign o_alu_own = o_busy;
  assign o_prod    = r_prod;

  // The ALU carry re-enters at the top of the active accumulator width.
  always_comb begin
    if (r_wr) begin
      w_acc_nx = {i_alu_co, i_alu_res[15:1]};
      w_q_nx   = {i_alu_res[0], r_q[15:1]};
    end else begin
      w_acc_nx = {8'h00, i_alu_co, i_alu_res[7:1]};
      w_q_nx   = {8'h00, i_alu_res[0], r_q[7:1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc  <= 16'h0000;
      r_q    <= 16'h0000;
      r_mc   <= 16'h0000;
      r_cnt  <= 4'd0;
      r_wr   <= 1'b0;
      r_prod <= 32'h0000_0000;
    end else if (w_load) begin
      r_acc <= 16'h0000;
      r_q   <= i_w16 ? i_mplier : {8'h00, i_mplier[7:0]};
      r_mc  <= i_w16 ? i_mcand : {8'h00, i_mcand[7:0]};
      r_wr  <= i_w16;
      r_cnt <= i_w16 ? 4'd15 : 4'd7;
    end else if (w_step) begin
      r_acc <= w_acc_nx;
      r_q   <= w_q_nx;
      if (w_last) begin
        r_prod <= r_wr ? {w_acc_nx, w_q_nx} : {16'h0000, w_acc_nx[7:0], w_q_nx[7:0]};
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq; a behavioural adder stands in for the shared ALU.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        start;
  logic        w16;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] prod;
  logic        alu_own;
  logic [15:0] alu_l;
  logic [15:0] alu_r;
  logic [2:0]  alu_fstop;
  logic [2:0]  alu_secop;
  logic        alu_fc;
  logic        alu_w16;
  logic        alu_bcd;
  logic        alu_ci;
  logic [15:0] alu_res;
  logic        alu_co;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mul_seq #(.CE_GATE(1'b1)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ce       (ce),
    .i_start    (start),
    .i_w16      (w16),
    .i_mcand    (mcand),
    .i_mplier   (mplier),
    .o_busy     (busy),
    .o_done     (done),
    .o_prod     (prod),
    .o_alu_own  (alu_own),
    .o_alu_l    (alu_l),
    .o_alu_r    (alu_r),
    .o_alu_fstop(alu_fstop),
    .o_alu_secop(alu_secop),
    .o_alu_fc   (alu_fc),
    .o_alu_w16  (alu_w16),
    .o_alu_bcd  (alu_bcd),
    .o_alu_ci   (alu_ci),
    .i_alu_res  (alu_res),
    .i_alu_co   (alu_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: pass R then add L with carry, at the requested width.
  always_comb begin
    logic [16:0] s16;
    logic [8:0]  s8;
    s16 = {1'b0, alu_l} + {1'b0, alu_r} + {16'h0000, alu_ci};
    s8  = {1'b0, alu_l[7:0]} + {1'b0, alu_r[7:0]} + {8'h00, alu_ci};
    if (alu_w16) begin
      alu_res = s16[15:0];
      alu_co  = s16[16];
    end else begin
      alu_res = {8'h00, s8[7:0]};
      alu_co  = s8[8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic w, input logic [15:0] a, input logic [15:0] b);
    w16 = w; mcand = a; mplier = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advances until DONE is seen; cycle counting continues from cyc_in.
  task automatic wait_done(input int cyc_in, input logic exp_w16, output int cyc,
                           output int busy_cyc, output bit alu_bad, output bit timeout);
    cyc = cyc_in; busy_cyc = 0; alu_bad = 0; timeout = 0;
    while (!done) begin
      if (busy) begin
        busy_cyc++;
        if (alu_w16 !== exp_w16 || alu_secop !== 3'b011 || alu_fstop !== 3'b100 ||
            alu_own !== 1'b1) alu_bad = 1;
      end
      if (cyc > 60) begin
        timeout = 1;
        return;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; start = 1'b0; w16 = 1'b0; mcand = 16'h0; mplier = 16'h0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_own !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags busy=%b done=%b own=%b expected 000", busy, done, alu_own);
    end
    n_checks++;
    if (prod !== 32'h0) begin
      n_fail++; $display("FAIL reset_prod got %h expected 00000000", prod);
    end
    n_checks++;
    if (alu_l !== 16'h0 || alu_r !== 16'h0 || alu_secop !== 3'b0 || alu_fstop !== 3'b0 || alu_w16 !== 1'b0) begin
      n_fail++; $display("FAIL reset_alu_idle l=%h r=%h sec=%b fst=%b w=%b expected all 0",
                         alu_l, alu_r, alu_secop, alu_fstop, alu_w16);
    end
  endtask

  task automatic test_mul8();
    int cyc, bc; bit bad, to;
    launch(1'b0, 16'h00FF, 16'h00FF);
    wait_done(1, 1'b0, cyc, bc, bad, to);
    n_checks++;
    if (to || cyc != 9) begin
      n_fail++; $display("FAIL mul8_latency got %0d timeout=%0d expected 9", cyc, to);
    end
    n_checks++;
    if (bc != 8) begin
      n_fail++; $display("FAIL mul8_busy_cycles got %0d expected 8", bc);
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL mul8_alu_ctrl got bad control during RUN expected w16=0 secop=011");
    end
    n_checks++;
    if (prod !== 32'h0000FE01) begin
      n_fail++; $display("FAIL mul8_prod got %h expected 0000fe01", prod);
    end
    tick();
  endtask

  task automatic test_mul16();
    int cyc, bc; bit bad, to;
    launch(1'b1, 16'hFFFF, 16'hFFFF);
    wait_done(1, 1'b1, cyc, bc, bad, to);
    n_checks++;
    if (to || cyc != 17 || bc != 16) begin
      n_fail++; $display("FAIL mul16_latency got cyc=%0d busy=%0d expected 17/16", cyc, bc);
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL mul16_alu_ctrl got bad control during RUN expected w16=1 secop=011");
    end
    n_checks++;
    if (prod !== 32'hFFFE0001) begin
      n_fail++; $display("FAIL mul16_prod got %h expected fffe0001", prod);
    end
    tick();
    launch(1'b1, 16'h1234, 16'h0000);
    n_checks++;
    if (prod !== 32'hFFFE0001) begin
      n_fail++; $display("FAIL prod_hold_at_load got %h expected fffe0001", prod);
    end
    wait_done(1, 1'b1, cyc, bc, bad, to);
    n_checks++;
    if (to || cyc != 17 || prod !== 32'h0) begin
      n_fail++; $display("FAIL mul16_zero got cyc=%0d prod=%h expected 17 00000000", cyc, prod);
    end
    tick();
  endtask

  task automatic test_ce_stall();
    int cyc, bc; bit bad, to, unstable;
    logic [15:0] l0, r0;
    launch(1'b1, 16'h0003, 16'h0005);
    tick(); tick(); tick();
    ce = 1'b0;
    #1;
    l0 = alu_l; r0 = alu_r; unstable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (alu_l !== l0 || alu_r !== r0 || busy !== 1'b1 || done !== 1'b0) unstable = 1;
    end
    ce = 1'b1;
    n_checks++;
    if (unstable) begin
      n_fail++; $display("FAIL ce_alu_stable got change while stalled expected l=%h r=%h held", l0, r0);
    end
    wait_done(9, 1'b1, cyc, bc, bad, to);
    n_checks++;
    if (to || cyc != 22) begin
      n_fail++; $display("FAIL ce_latency got %0d expected 22", cyc);
    end
    n_checks++;
    if (prod !== 32'h0000000F) begin
      n_fail++; $display("FAIL ce_prod got %h expected 0000000f", prod);
    end
    ce = 1'b0;
    tick(); tick();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL ce_done_hold got %b expected 1", done);
    end
    ce = 1'b1;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ce_done_release got done=%b busy=%b expected 0 0", done, busy);
    end
    ce = 1'b0; start = 1'b1; w16 = 1'b1; mcand = 16'h0002; mplier = 16'h0002;
    tick();
    start = 1'b0; ce = 1'b1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL ce_start_ignored got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc; bit bad, to;
    launch(1'b1, 16'h0007, 16'h0009);
    tick(); tick();
    start = 1'b1; w16 = 1'b0; mcand = 16'hFFFF; mplier = 16'hFFFF;
    tick();
    start = 1'b0;
    wait_done(4, 1'b1, cyc, bc, bad, to);
    n_checks++;
    if (to || cyc != 17 || prod !== 32'h0000003F) begin
      n_fail++; $display("FAIL restart_in_run got cyc=%0d prod=%h expected 17 0000003f", cyc, prod);
    end
    start = 1'b1; w16 = 1'b1; mcand = 16'h0002; mplier = 16'h0003;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || prod !== 32'h0000003F) begin
      n_fail++; $display("FAIL start_in_done got busy=%b done=%b prod=%h expected 0 0 0000003f",
                         busy, done, prod);
    end
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL start_next_idle got busy=%b expected 1", busy);
    end
    wait_done(1, 1'b1, cyc, bc, bad, to);
    n_checks++;
    if (to || prod !== 32'h00000006) begin
      n_fail++; $display("FAIL b2b_prod got %h expected 00000006", prod);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int cyc, bc; bit bad, to, saw_done;
    launch(1'b1, 16'hFFFF, 16'hFFFF);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || alu_own !== 1'b0 || prod !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_run got busy=%b own=%b prod=%h expected 0 0 00000000",
                         busy, alu_own, prod);
    end
    saw_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) saw_done = 1;
      tick();
    end
    n_checks++;
    if (saw_done) begin
      n_fail++; $display("FAIL reset_no_done got a DONE pulse expected none");
    end
    launch(1'b1, 16'h0010, 16'h0010);
    wait_done(1, 1'b1, cyc, bc, bad, to);
    n_checks++;
    if (to || cyc != 17 || prod !== 32'h00000100) begin
      n_fail++; $display("FAIL post_reset_mul got cyc=%0d prod=%h expected 17 00000100", cyc, prod);
    end
    tick();
  endtask

  task automatic test_mul8_upper_ignored();
    int cyc, bc; bit bad, to;
    launch(1'b0, 16'hAA12, 16'h5534);
    wait_done(1, 1'b0, cyc, bc, bad, to);
    n_checks++;
    if (to || cyc != 9 || prod !== 32'h000003A8) begin
      n_fail++; $display("FAIL mul8_upper got cyc=%0d prod=%h expected 9 000003a8", cyc, prod);
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL mul8_upper_ctrl got bad control during RUN expected w16=0");
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_mul8();
    test_mul16();
    test_ce_stall();
    test_back_to_back();
    test_reset_mid_run();
    test_mul8_upper_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
